fifo_stream_reader: RTL
=======================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DATA_W, default 18, sets the FIFO word and output data width.
REQ-002 Parameter CNT_W, default 32, sets the delivered-word counter width.
REQ-003 clk_100MHz  input  1  single clock; all logic on rising edge.
REQ-004 reset_rtl_0  input  1  synchronous active-high reset.
REQ-005 fifo_rd_en  output  1  read strobe to the synchronous FIFO read port.
REQ-006 fifo_dout  input  DATA_W  FIFO read data, valid exactly 1 cycle after the fifo_rd_en cycle.
REQ-007 fifo_empty  input  1  FIFO empty flag.
REQ-008 m_data  output  DATA_W  output stream data.
REQ-009 m_valid  output  1  m_data holds a word.
REQ-010 m_ready  input  1  downstream accepts; transfer = m_valid & m_ready.
REQ-011 words_out  output  CNT_W  count of delivered words; present only with READER_CNT_EN.

Function
REQ-012 The block SHALL drain the FIFO read port into a valid/ready stream through a 2-entry output buffer, preserving word order with no loss or duplication.
REQ-013 State SHALL be: occ (0..2, buffered words), inflight (1 bit, read issued last cycle, data arriving this cycle).
REQ-014 pop = m_valid & m_ready; fifo_rd_en SHALL equal !fifo_empty & (occ + inflight - pop < 2), combinationally.
REQ-015 When inflight=1, fifo_dout SHALL be captured into the buffer that cycle; inflight next = fifo_rd_en.
REQ-016 occ next = occ + inflight - pop; occ SHALL never exceed 2, and fifo_rd_en SHALL never be asserted while fifo_empty=1.
REQ-017 m_valid SHALL equal (occ != 0); m_data SHALL be the oldest buffered word and SHALL hold stable while m_valid & !m_ready.
REQ-018 Capture and pop in the same cycle SHALL both take effect; the captured word queues behind the remaining entry.
REQ-019 Latency: FIFO non-empty with occ=0 and inflight=0 at cycle N -> fifo_rd_en at N, m_valid at N+2.
REQ-020 With m_ready held high and the FIFO non-empty, the block SHALL sustain one word per cycle after fill.
REQ-021 With m_ready low, at most 2 reads SHALL be outstanding or buffered; fifo_rd_en SHALL deassert once occ+inflight reaches 2.

Reset
REQ-022 Reset SHALL clear occ, inflight and words_out to 0; fifo_rd_en=0 and m_valid=0 during the reset cycle.
REQ-023 Reset mid-stream SHALL discard buffered and in-flight words; data on fifo_dout in the first post-reset cycle SHALL be ignored.
REQ-024 m_data SHALL read 0 after reset until the first capture.

Configuration
REQ-025 Macro READER_CNT_EN defined: words_out SHALL increment by 1 per transfer and wrap modulo 2^CNT_W; it is cleared by reset.
REQ-026 READER_CNT_EN undefined: the words_out port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Shared package fifo_pkg SHALL hold FIFO_DATA_W=18, READ_LATENCY=1 and the occupancy type (2-bit).
REQ-028 The 2-entry buffer SHALL be a sub-module skid_buf2 with a push/pop/occ interface; the read-issue logic stays in the top.

Verification
REQ-029 Reset, preload the FIFO model with 0x00001,0x00002,0x00003, m_ready=1 -> m_data 1,2,3 on consecutive cycles starting 2 cycles after first rd_en; words_out=3.
REQ-030 FIFO holds 10 words, m_ready=0 -> exactly 2 rd_en pulses; m_valid=1, m_data=first word and stable; set m_ready=1 -> all 10 words delivered in order.
REQ-031 fifo_empty toggled randomly, m_ready random for 5000 cycles with 18-bit random data -> scoreboard matches in order; no rd_en while empty; occ never >2.
REQ-032 Reset asserted while occ=2 and inflight=1 -> next cycle m_valid=0 and words_out=0; the stale fifo_dout word never appears at m_data.
REQ-033 With CNT_W=4 and READER_CNT_EN defined, 17 transfers -> words_out=1 (wrap); build without the macro -> compiles with no words_out port.
REQ-034 Single word 0x3FFFF, m_ready pulsed high one cycle after m_valid -> one transfer, m_valid drops next cycle, fifo_rd_en stays 0.

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO stream reader: FIFO word width, read-port
// latency, buffer occupancy type and the occupancy projection helper.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_W  = 18;
    localparam int unsigned READ_LATENCY = 1;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_MAX = 2'd2;

    // Words that will be held next cycle: buffered + arriving - leaving.
    function automatic logic [2:0] occ_after(input occ_t occ, input logic inflight, input logic pop);
        return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Bundle of the FIFO read port and the valid/ready output stream.
// master: the reader block; slave: the FIFO and the downstream consumer.
interface fifo_stream_reader_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W
);

    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output fifo_rd_en,
        input  fifo_dout,
        input  fifo_empty,
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_dout,
        output fifo_empty,
        input  m_data,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/fifo_stream_reader_skid_buf2.sv
// Two-entry in-order word buffer. head is the oldest word; a push and a pop
// in the same cycle both take effect, the pushed word queuing behind any
// remaining entry. The caller guarantees no push when full and no pop when
// empty.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output occ_t              occ,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] tail;

    // Occupancy and the two storage slots; head reads 0 until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ  <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head <= push_data;
                    end else begin
                        tail <= push_data;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    if (occ == OCC_MAX) begin
                        head <= tail;
                    end
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == OCC_MAX) begin
                        head <= tail;
                        tail <= push_data;
                    end else begin
                        head <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO read port (data one cycle after the read strobe)
// into a valid/ready stream through a two-entry buffer. Reads are issued only
// while buffered plus in-flight words stay below two after this cycle's pop.
// Optional feature: define READER_CNT_EN to add the words_out delivered-word
// counter port (wraps modulo 2^CNT_W).
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                  clk_100MHz,
    input  logic                  reset_rtl_0,
    fifo_stream_reader_if.master  bus
`ifdef READER_CNT_EN
    ,
    output logic [CNT_W-1:0]      words_out
`endif
);

    occ_t                    occ;
    logic [DATA_W-1:0]       head;
    logic [READ_LATENCY-1:0] rd_pipe;
    logic                    inflight;
    logic                    valid;
    logic                    pop;
    logic                    rd_en;

    assign inflight = rd_pipe[READ_LATENCY-1];

    // Outputs are held inactive during the reset cycle regardless of old state.
    assign valid = (occ != '0) && !reset_rtl_0;
    assign pop   = valid && bus.m_ready;
    assign rd_en = !reset_rtl_0 && !bus.fifo_empty && (occ_after(occ, inflight, pop) < 3'd2);

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = valid;
    assign bus.m_data     = head;

    // Track the read issued last cycle; its data is on fifo_dout this cycle.
    always_ff @(posedge clk_100MHz) begin
        if (reset_rtl_0) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe <= READ_LATENCY'({rd_pipe, rd_en});
        end
    end

    skid_buf2 #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (clk_100MHz),
        .rst       (reset_rtl_0),
        .push      (inflight),
        .push_data (bus.fifo_dout),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

`ifdef READER_CNT_EN
    // Count every accepted output word.
    always_ff @(posedge clk_100MHz) begin
        if (reset_rtl_0) begin
            words_out <= '0;
        end else if (pop) begin
            words_out <= words_out + 1'b1;
        end
    end
`endif

endmodule
